// File: rtl/uart_tx_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arb
//  Purpose  : Round-robin arbiter sharing one UART transmitter between two
//             byte-stream requesters. A requester keeps the grant for a whole
//             message (up to tlast). An owner that goes quiet mid-message is
//             released by an idle timeout with a one-cycle abort pulse.
//             A single output holding register feeds the transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arb #(
   parameter int TIMEOUT = 255            // idle owner cycles before release (1..65535)
) (
   input  logic       clk,
   input  logic       rst,

   input  logic [7:0] req0_tdata,
   input  logic       req0_tvalid,
   input  logic       req0_tlast,
   output logic       req0_tready,

   input  logic [7:0] req1_tdata,
   input  logic       req1_tvalid,
   input  logic       req1_tlast,
   output logic       req1_tready,

   output logic [7:0] output_axis_tdata,
   output logic       output_axis_tvalid,
   input  logic       output_axis_tready,

   output logic [1:0] grant,
   output logic       abort
);

   // Timeout threshold held at the counter width.
   localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   state_t      r_state;
   logic [1:0]  r_grant;        // one-hot owner, 00 while idle
   logic        r_last_owner;   // 0 = req0 owned last, 1 = req1 owned last
   logic [15:0] r_idle_cnt;     // owner-idle cycles inside the current message
   logic [7:0]  r_out_data;
   logic        r_out_valid;
   logic        r_abort;

   logic        w_accept;
   logic        w_ready0;
   logic        w_ready1;
   logic        w_own_valid;
   logic [7:0]  w_own_data;
   logic        w_own_last;
   logic        w_owner_id;
   logic        w_hs;
   logic        w_cnt_inc;
   logic [15:0] w_cnt_next;
   logic        w_timeout;
   logic        w_pick1;

   // Output register can take a byte when empty or emptying this cycle.
   assign w_accept = !r_out_valid || output_axis_tready;

   // Ready only to the current owner; grant is 00 while idle so both are low.
   assign w_ready0 = r_grant[0] & w_accept;
   assign w_ready1 = r_grant[1] & w_accept;

   // Owner-side view of the selected stream.
   assign w_owner_id  = r_grant[1];
   assign w_own_valid = (r_grant[0] & req0_tvalid) | (r_grant[1] & req1_tvalid);
   assign w_own_data  = r_grant[1] ? req1_tdata : req0_tdata;
   assign w_own_last  = r_grant[1] ? req1_tlast : req0_tlast;

   // A byte moves from the owner into the holding register this cycle.
   assign w_hs = (req0_tvalid & w_ready0) | (req1_tvalid & w_ready1);

   // The counter only advances while the owner itself is silent; a
   // downstream stall with the owner still valid does not count.
   assign w_cnt_inc  = (r_state == ST_LOCK) && !w_own_valid;
   assign w_cnt_next = r_idle_cnt + {15'd0, w_cnt_inc};
   assign w_timeout  = w_cnt_inc && (w_cnt_next == c_TIMEOUT);

   // Arbitration: on a tie the requester that did not own last wins.
   assign w_pick1 = req1_tvalid && (!req0_tvalid || !r_last_owner);

   // Arbiter state machine, idle counter and output holding register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_grant      <= 2'b00;
         r_last_owner <= 1'b1;
         r_idle_cnt   <= 16'd0;
         r_out_data   <= 8'h00;
         r_out_valid  <= 1'b0;
         r_abort      <= 1'b0;
      end else begin
         r_abort <= 1'b0;

         // Holding register loads on a handshake and drains whenever the
         // transmitter takes it, independent of who owns the grant.
         if (w_hs) begin
            r_out_data  <= w_own_data;
            r_out_valid <= 1'b1;
         end else if (output_axis_tready) begin
            r_out_valid <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               r_idle_cnt <= 16'd0;
               if (req0_tvalid || req1_tvalid) begin
                  r_state <= ST_LOCK;
                  r_grant <= w_pick1 ? 2'b10 : 2'b01;
               end
            end

            ST_LOCK: begin
               if (w_hs) begin
                  // A real byte always beats a timeout in the same cycle.
                  r_idle_cnt <= 16'd0;
                  if (w_own_last) begin
                     r_state      <= ST_IDLE;
                     r_grant      <= 2'b00;
                     r_last_owner <= w_owner_id;
                  end
               end else if (w_timeout) begin
                  r_state      <= ST_IDLE;
                  r_grant      <= 2'b00;
                  r_last_owner <= w_owner_id;
                  r_idle_cnt   <= 16'd0;
                  r_abort      <= 1'b1;
               end else begin
                  r_idle_cnt <= w_cnt_next;
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_grant <= 2'b00;
            end
         endcase
      end
   end

   assign req0_tready        = w_ready0;
   assign req1_tready        = w_ready1;
   assign output_axis_tdata  = r_out_data;
   assign output_axis_tvalid = r_out_valid;
   assign grant              = r_grant;
   assign abort              = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arb
//  Purpose  : Self-checking bench for uart_tx_arb. Expected output bytes are
//             queued when stimulus is planned and compared as the DUT emits.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req0_tdata, req1_tdata;
   logic       req0_tvalid, req0_tlast, req0_tready;
   logic       req1_tvalid, req1_tlast, req1_tready;
   logic [7:0] output_axis_tdata;
   logic       output_axis_tvalid;
   logic       output_axis_tready;
   logic [1:0] grant;
   logic       abort;

   int n_total = 0;
   int n_pass  = 0;
   int n_abort = 0;
   logic [7:0] sb[$];

   always #5 clk = ~clk;

   uart_tx_arb #(.TIMEOUT(TO)) dut (
      .clk                (clk),
      .rst                (rst),
      .req0_tdata         (req0_tdata),
      .req0_tvalid        (req0_tvalid),
      .req0_tlast         (req0_tlast),
      .req0_tready        (req0_tready),
      .req1_tdata         (req1_tdata),
      .req1_tvalid        (req1_tvalid),
      .req1_tlast         (req1_tlast),
      .req1_tready        (req1_tready),
      .output_axis_tdata  (output_axis_tdata),
      .output_axis_tvalid (output_axis_tvalid),
      .output_axis_tready (output_axis_tready),
      .grant              (grant),
      .abort              (abort)
   );

   // Scoreboard: every byte taken by the transmitter must be the next expected one.
   always @(negedge clk) begin
      logic [7:0] exp_b;
      if (output_axis_tvalid === 1'b1 && output_axis_tready === 1'b1) begin
         n_total++;
         if (sb.size() == 0) begin
            $display("FAIL sb_unexpected: got byte %02h, expected no output", output_axis_tdata);
         end else begin
            exp_b = sb.pop_front();
            if (output_axis_tdata !== exp_b)
               $display("FAIL sb_data: got %02h, expected %02h", output_axis_tdata, exp_b);
            else
               n_pass++;
         end
      end
      if (abort === 1'b1) n_abort++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sends an n-byte message from one requester, holding each byte until accepted.
   task automatic send_msg(input int id, input logic [7:0] base, input int n);
      logic got;
      for (int i = 0; i < n; i++) begin
         got = 1'b0;
         if (id == 0) begin
            req0_tdata = base + 8'(i); req0_tlast = (i == n - 1); req0_tvalid = 1'b1;
         end else begin
            req1_tdata = base + 8'(i); req1_tlast = (i == n - 1); req1_tvalid = 1'b1;
         end
         for (int w = 0; w < 200 && !got; w++) begin
            @(negedge clk);
            got = (id == 0) ? req0_tready : req1_tready;
         end
         if (!got) begin
            n_total++;
            $display("FAIL send_wait: req%0d byte %0d tready=0, expected 1 within 200 cycles", id, i);
         end
         @(posedge clk);
         #1;
         if (id == 0) begin req0_tvalid = 1'b0; req0_tlast = 1'b0; end
         else         begin req1_tvalid = 1'b0; req1_tlast = 1'b0; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_tdata = 8'h00; req0_tvalid = 1'b0; req0_tlast = 1'b0;
      req1_tdata = 8'h00; req1_tvalid = 1'b0; req1_tlast = 1'b0;
      output_axis_tready = 1'b1;
      repeat (3) tick();
      n_total++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b, expected 00", grant); else n_pass++;
      n_total++; if (output_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b, expected 0", output_axis_tvalid); else n_pass++;
      n_total++; if (output_axis_tdata !== 8'h00) $display("FAIL reset_tdata: got %02h, expected 00", output_axis_tdata); else n_pass++;
      n_total++; if (abort !== 1'b0) $display("FAIL reset_abort: got %b, expected 0", abort); else n_pass++;
      n_total++; if ({req0_tready, req1_tready} !== 2'b00) $display("FAIL reset_tready: got %b, expected 00", {req0_tready, req1_tready}); else n_pass++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      sb.push_back(8'hA1); sb.push_back(8'hA2); sb.push_back(8'hA3);
      req0_tdata = 8'hA1; req0_tlast = 1'b0; req0_tvalid = 1'b1;          // cycle 0
      tick();                                                             // cycle 1
      n_total++; if (grant !== 2'b01) $display("FAIL single_grant: got %b, expected 01", grant); else n_pass++;
      n_total++; if ({req1_tready, req0_tready} !== 2'b01) $display("FAIL single_tready: got %b, expected 01", {req1_tready, req0_tready}); else n_pass++;
      tick();                                                             // cycle 2
      n_total++; if ({output_axis_tvalid, output_axis_tdata} !== {1'b1, 8'hA1}) $display("FAIL single_out_c2: got %b/%02h, expected 1/A1", output_axis_tvalid, output_axis_tdata); else n_pass++;
      req0_tdata = 8'hA2;
      tick();                                                             // cycle 3
      n_total++; if (output_axis_tdata !== 8'hA2) $display("FAIL single_out_c3: got %02h, expected A2", output_axis_tdata); else n_pass++;
      req0_tdata = 8'hA3; req0_tlast = 1'b1;
      tick();                                                             // cycle 4
      n_total++; if (output_axis_tdata !== 8'hA3) $display("FAIL single_out_c4: got %02h, expected A3", output_axis_tdata); else n_pass++;
      n_total++; if (grant !== 2'b00) $display("FAIL single_release: got %b, expected 00", grant); else n_pass++;
      req0_tvalid = 1'b0; req0_tlast = 1'b0;
      tick();                                                             // cycle 5
      n_total++; if (output_axis_tvalid !== 1'b0) $display("FAIL single_drain: got %b, expected 0", output_axis_tvalid); else n_pass++;
      tick();
   endtask

   task automatic test_tie_rr();
      logic [1:0] g_seen[$];
      int         c_seen[$];
      logic [1:0] prev;
      rst = 1'b1; tick(); rst = 1'b0;                                     // cycle 0
      sb.push_back(8'hC0); sb.push_back(8'hD0); sb.push_back(8'hC1); sb.push_back(8'hD1);
      prev = 2'b00;
      fork
         begin send_msg(0, 8'hC0, 1); send_msg(0, 8'hC1, 1); end
         begin send_msg(1, 8'hD0, 1); send_msg(1, 8'hD1, 1); end
         begin
            for (int c = 0; c < 16; c++) begin
               @(negedge clk);
               if (grant != 2'b00 && prev == 2'b00) begin g_seen.push_back(grant); c_seen.push_back(c); end
               prev = grant;
            end
         end
      join
      tick();
      n_total++;
      if (g_seen.size() != 4) $display("FAIL tie_grant_count: got %0d grants, expected 4", g_seen.size());
      else begin
         n_pass++;
         for (int k = 0; k < 4; k++) begin
            n_total++; if (g_seen[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) $display("FAIL tie_owner%0d: got %b, expected %b", k, g_seen[k], (k % 2 == 0) ? 2'b01 : 2'b10); else n_pass++;
            n_total++; if (c_seen[k] != 1 + 2 * k) $display("FAIL tie_cycle%0d: got %0d, expected %0d", k, c_seen[k], 1 + 2 * k); else n_pass++;
         end
      end
   endtask

   task automatic test_backpressure();
      int ab0;
      ab0 = n_abort;
      for (int i = 0; i < 4; i++) sb.push_back(8'hE0 + 8'(i));
      fork
         send_msg(0, 8'hE0, 4);
         begin
            for (int i = 0; i < 20; i++) begin
               if (output_axis_tvalid) break;
               tick();
            end
            output_axis_tready = 1'b0;
            #1;
            for (int i = 0; i < 5; i++) begin
               n_total++; if (req0_tready !== 1'b0) $display("FAIL bp_tready%0d: got %b, expected 0", i, req0_tready); else n_pass++;
               n_total++; if ({output_axis_tvalid, output_axis_tdata} !== {1'b1, 8'hE0}) $display("FAIL bp_hold%0d: got %b/%02h, expected 1/E0", i, output_axis_tvalid, output_axis_tdata); else n_pass++;
               n_total++; if (abort !== 1'b0) $display("FAIL bp_abort%0d: got %b, expected 0", i, abort); else n_pass++;
               tick();
            end
            output_axis_tready = 1'b1;
         end
      join
      repeat (3) tick();
      n_total++; if (n_abort - ab0 != 0) $display("FAIL bp_abort_count: got %0d, expected 0", n_abort - ab0); else n_pass++;
      n_total++; if (sb.size() != 0) $display("FAIL bp_sb_left: got %0d pending, expected 0", sb.size()); else n_pass++;
   endtask

   task automatic test_timeout();
      int ab0;
      ab0 = n_abort;
      sb.push_back(8'h90); sb.push_back(8'hA0);
      req1_tdata = 8'h90; req1_tlast = 1'b0; req1_tvalid = 1'b1;          // cycle 0
      tick();                                                             // cycle 1
      n_total++; if (grant !== 2'b10) $display("FAIL to_grant1: got %b, expected 10", grant); else n_pass++;
      n_total++; if (req0_tready !== 1'b0) $display("FAIL to_nonowner_ready: got %b, expected 0", req0_tready); else n_pass++;
      req0_tdata = 8'hA0; req0_tlast = 1'b1; req0_tvalid = 1'b1;
      tick();                                                             // cycle 2
      n_total++; if ({output_axis_tvalid, output_axis_tdata} !== {1'b1, 8'h90}) $display("FAIL to_first_byte: got %b/%02h, expected 1/90", output_axis_tvalid, output_axis_tdata); else n_pass++;
      req1_tvalid = 1'b0;
      tick();
      for (int c = 3; c <= 5; c++) begin
         n_total++; if ({abort, grant} !== 3'b010) $display("FAIL to_wait_c%0d: got abort/grant %b/%b, expected 0/10", c, abort, grant); else n_pass++;
         tick();
      end                                                                 // cycle 6
      n_total++; if ({abort, grant} !== 3'b100) $display("FAIL to_abort: got abort/grant %b/%b, expected 1/00", abort, grant); else n_pass++;
      tick();                                                             // cycle 7
      n_total++; if ({abort, grant} !== 3'b001) $display("FAIL to_regrant: got abort/grant %b/%b, expected 0/01", abort, grant); else n_pass++;
      tick();                                                             // cycle 8
      req0_tvalid = 1'b0; req0_tlast = 1'b0;
      n_total++; if (grant !== 2'b00) $display("FAIL to_release: got %b, expected 00", grant); else n_pass++;
      repeat (2) tick();
      n_total++; if (n_abort - ab0 != 1) $display("FAIL to_abort_count: got %0d, expected 1", n_abort - ab0); else n_pass++;
   endtask

   task automatic test_reset_mid();
      req1_tdata = 8'h60; req1_tlast = 1'b0; req1_tvalid = 1'b1;          // cycle 0
      tick();                                                             // cycle 1
      tick();                                                             // cycle 2
      n_total++; if ({output_axis_tvalid, grant} !== 3'b110) $display("FAIL rm_setup: got tvalid/grant %b/%b, expected 1/10", output_axis_tvalid, grant); else n_pass++;
      req1_tdata = 8'h61; req1_tlast = 1'b1;
      req0_tdata = 8'h70; req0_tlast = 1'b1; req0_tvalid = 1'b1;
      rst = 1'b1;
      #1;
      n_total++; if ({output_axis_tvalid, grant, abort} !== 4'b0000) $display("FAIL rm_async: got tvalid/grant/abort %b/%b/%b, expected 0/00/0", output_axis_tvalid, grant, abort); else n_pass++;
      n_total++; if (output_axis_tdata !== 8'h00) $display("FAIL rm_tdata: got %02h, expected 00", output_axis_tdata); else n_pass++;
      n_total++; if ({req0_tready, req1_tready} !== 2'b00) $display("FAIL rm_tready: got %b, expected 00", {req0_tready, req1_tready}); else n_pass++;
      tick();
      rst = 1'b0;                                                         // post-reset cycle 0
      sb.push_back(8'h70); sb.push_back(8'h61);
      tick();                                                             // cycle 1
      n_total++; if (grant !== 2'b01) $display("FAIL rm_tie: got %b, expected 01", grant); else n_pass++;
      tick();                                                             // cycle 2
      req0_tvalid = 1'b0; req0_tlast = 1'b0;
      n_total++; if ({output_axis_tvalid, output_axis_tdata} !== {1'b1, 8'h70}) $display("FAIL rm_first: got %b/%02h, expected 1/70", output_axis_tvalid, output_axis_tdata); else n_pass++;
      tick();                                                             // cycle 3
      n_total++; if (grant !== 2'b10) $display("FAIL rm_second_grant: got %b, expected 10", grant); else n_pass++;
      tick();                                                             // cycle 4
      req1_tvalid = 1'b0; req1_tlast = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_tlast_at_timeout();
      int ab0;
      ab0 = n_abort;
      sb.push_back(8'hB0); sb.push_back(8'hB1);
      req0_tdata = 8'hB0; req0_tlast = 1'b0; req0_tvalid = 1'b1;          // cycle 0
      tick();                                                             // cycle 1
      tick();                                                             // cycle 2
      req0_tvalid = 1'b0;
      repeat (3) tick();                                                  // cycle 5
      n_total++; if ({abort, grant, req0_tready} !== 4'b0011) $display("FAIL tt_before: got abort/grant/ready %b/%b/%b, expected 0/01/1", abort, grant, req0_tready); else n_pass++;
      req0_tdata = 8'hB1; req0_tlast = 1'b1; req0_tvalid = 1'b1;
      tick();                                                             // cycle 6
      n_total++; if ({abort, grant} !== 3'b000) $display("FAIL tt_release: got abort/grant %b/%b, expected 0/00", abort, grant); else n_pass++;
      req0_tvalid = 1'b0; req0_tlast = 1'b0;
      repeat (3) tick();
      n_total++; if (n_abort - ab0 != 0) $display("FAIL tt_abort_count: got %0d, expected 0", n_abort - ab0); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie_rr();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      test_tlast_at_timeout();
      n_total++; if (sb.size() != 0) $display("FAIL final_sb_left: got %0d pending, expected 0", sb.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
